// File: rtl/pipeline_counter_pkg.sv
// pipeline_counter_pkg: shared FSM encoding and default sizing for the counter checker
package pipeline_counter_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
    localparam int DEF_WIDTH = 7;
    localparam int DEF_LAG = 1;
    localparam int DEF_SYNC_LEN = 4;
    localparam int DEF_ERR_W = 8;
endpackage

// File: rtl/pipeline_counter_checker_if.sv
// pipeline_counter_checker_if: stream inputs and status outputs of the counter checker
interface pipeline_counter_checker_if
    import pipeline_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) ();
    logic en;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt2;
    logic locked;
    logic seq_err;
    logic pipe_err;
    logic [ERR_W-1:0] err_cnt;
    logic [WIDTH-1:0] last_good;
    modport master (output en, cnt, cnt2, input locked, seq_err, pipe_err, err_cnt, last_good);
    modport slave (input en, cnt, cnt2, output locked, seq_err, pipe_err, err_cnt, last_good);
endinterface

// File: rtl/cnt_delay_line.sv
// cnt_delay_line: LAG-deep shift history of samples with per-stage valid tracking
module cnt_delay_line #(
    parameter int WIDTH = 7,
    parameter int LAG = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic valid
);
    logic [WIDTH-1:0] mem [LAG];
    logic [LAG-1:0] v;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v <= '0;
            for (int i = 0; i < LAG; i++) mem[i] <= '0;
        end else begin
            mem[0] <= d;
            v[0] <= 1'b1;
            for (int i = 1; i < LAG; i++) begin
                mem[i] <= mem[i-1];
                v[i] <= v[i-1];
            end
        end
    end
    assign q = mem[LAG-1];
    assign valid = v[LAG-1];
endmodule

// File: rtl/pipeline_counter_checker.sv
// pipeline_counter_checker: locks onto an incrementing counter and flags sequence breaks and pipeline-copy mismatches
module pipeline_counter_checker
    import pipeline_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAG = DEF_LAG,
    parameter int SYNC_LEN = DEF_SYNC_LEN,
    parameter int ERR_W = DEF_ERR_W
) (
    input logic clk,
    input logic rst,
    pipeline_counter_checker_if.slave bus
);
    localparam int RUN_W = $clog2(SYNC_LEN + 1);
    state_t state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] hist_q;
    logic hist_v;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_n;
    logic good;
    logic pipe_bad;
    always_comb begin
        good = bus.cnt == prev + WIDTH'(1);
        pipe_bad = hist_v && (bus.cnt2 != hist_q);
        run_n = good ? run + RUN_W'(1) : '0;
    end
    // History only fills once SYNC is entered, so IDLE keeps it flushed
    cnt_delay_line #(.WIDTH(WIDTH), .LAG(LAG)) u_hist (
        .clk(clk),
        .rst(rst),
        .flush(!bus.en || state == IDLE),
        .d(bus.cnt),
        .q(hist_q),
        .valid(hist_v)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prev <= '0;
            run <= '0;
            bus.locked <= 1'b0;
            bus.seq_err <= 1'b0;
            bus.pipe_err <= 1'b0;
            bus.err_cnt <= '0;
            bus.last_good <= '0;
        end else if (!bus.en) begin
            state <= IDLE;
            bus.locked <= 1'b0;
            bus.seq_err <= 1'b0;
            bus.pipe_err <= 1'b0;
        end else begin
            if ((bus.seq_err || bus.pipe_err) && bus.err_cnt != '1)
                bus.err_cnt <= bus.err_cnt + ERR_W'(1);
            bus.seq_err <= 1'b0;
            bus.pipe_err <= 1'b0;
            prev <= bus.cnt;
            case (state)
                IDLE: begin
                    run <= '0;
                    state <= SYNC;
                end
                SYNC: begin
                    run <= run_n;
                    if (run_n == RUN_W'(SYNC_LEN)) begin
                        state <= LOCKED;
                        bus.locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    bus.pipe_err <= pipe_bad;
                    if (!good) begin
                        bus.seq_err <= 1'b1;
                        run <= '0;
                        state <= SYNC;
                        bus.locked <= 1'b0;
                    end else begin
                        bus.last_good <= bus.cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
